// File: rtl/gray_frame_writer.sv
// Grayscale frame-buffer writer: accepts 8-bit pixels over valid/ready and writes
// them in raster order through a single-entry request register to a frame buffer.
module gray_frame_writer #(
    parameter int H      = 391,
    parameter int W      = 317,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic              mem_ready,
    output logic              busy,
    output logic              frame_done,
    output logic              overflow
);

    localparam int ROW_W = (H > 1) ? $clog2(H) : 1;
    localparam int COL_W = (W > 1) ? $clog2(W) : 1;
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(H - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(W - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        FLUSH   = 2'd2
    } state_t;

    state_t             state;
    logic [ADDR_W-1:0]  pix_cnt;
    logic [ROW_W-1:0]   row;
    logic [COL_W-1:0]   col;
    logic               accept;
    logic               retire;
    logic               last_pix;

    // The request register can take a new pixel whenever it is empty or is
    // being retired on this very edge, giving one pixel per cycle.
    assign retire   = mem_we & mem_ready;
    assign in_ready = (state == CAPTURE) & (~mem_we | mem_ready);
    assign accept   = in_valid & in_ready;
    assign last_pix = (row == ROW_LAST) && (col == COL_LAST);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
            pix_cnt    <= '0;
            row        <= '0;
            col        <= '0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid)
                        overflow <= 1'b1;
                    // frame_done is still high on the first IDLE cycle; a start
                    // coinciding with it belongs to the finished frame and is dropped.
                    if (start && !frame_done) begin
                        state    <= CAPTURE;
                        pix_cnt  <= '0;
                        row      <= '0;
                        col      <= '0;
                        overflow <= 1'b0;
                    end
                end
                CAPTURE: begin
                    if (retire)
                        mem_we <= 1'b0;
                    if (accept) begin
                        mem_we    <= 1'b1;
                        mem_wdata <= in_data;
                        mem_addr  <= pix_cnt;
                        pix_cnt   <= pix_cnt + ADDR_W'(1);
                        if (col == COL_LAST) begin
                            col <= '0;
                            row <= row + ROW_W'(1);
                        end else begin
                            col <= col + COL_W'(1);
                        end
                        if (last_pix)
                            state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (retire) begin
                        mem_we     <= 1'b0;
                        frame_done <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gray_frame_writer.sv
// Directed bench for gray_frame_writer: a 2x3 frame instance for handshake and
// backpressure cases, plus a 4x317 instance for long-row wrap and frame end.
module tb_gray_frame_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, in_valid, mem_ready;
    logic [7:0]  in_data;
    logic        in_ready, mem_we, busy, frame_done, overflow;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;

    logic        start_b, in_valid_b, mem_ready_b;
    logic [7:0]  in_data_b;
    logic        in_ready_b, mem_we_b, busy_b, frame_done_b, overflow_b;
    logic [31:0] mem_addr_b;
    logic [7:0]  mem_wdata_b;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [31:0] la[$];
    logic [7:0]  ld[$];
    int          lc[$];
    int          done_a = 0;
    int          done_cyc = 0;
    int          rmode = 0;
    int          stall_n = 0;
    int          hold_bad = 0;

    int          b_wr_cnt = 0;
    int          b_seq_err = 0;
    int          b_done = 0;
    logic [31:0] b_last = '0;

    gray_frame_writer #(.H(2), .W(3), .ADDR_W(32)) dut_a (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .busy(busy), .frame_done(frame_done), .overflow(overflow)
    );

    gray_frame_writer #(.H(4), .W(317), .ADDR_W(32)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .in_valid(in_valid_b), .in_data(in_data_b),
        .in_ready(in_ready_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
        .mem_ready(mem_ready_b), .busy(busy_b), .frame_done(frame_done_b), .overflow(overflow_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Write log of retired requests for the small instance
    always @(posedge clk) begin
        if (mem_we && mem_ready && !rst) begin
            la.push_back(mem_addr);
            ld.push_back(mem_wdata);
            lc.push_back(cyc);
        end
        if (frame_done) begin
            done_a++;
            done_cyc = cyc;
        end
    end

    always @(posedge clk) begin
        if (mem_we_b && mem_ready_b && !rst) begin
            if (mem_addr_b != 32'(b_wr_cnt) || mem_wdata_b != 8'(b_wr_cnt))
                b_seq_err++;
            b_last = mem_addr_b;
            b_wr_cnt++;
        end
        if (frame_done_b)
            b_done++;
    end

    // Frame-buffer responder: always ready, stall addr 2 three times, or random
    always @(negedge clk) begin
        if (rmode == 0) begin
            mem_ready = 1'b1;
        end else if (rmode == 1) begin
            if (mem_we && mem_addr == 32'd2 && stall_n < 3) begin
                mem_ready = 1'b0;
                stall_n++;
                #1;
                if (mem_addr != 32'd2 || mem_wdata != 8'd22 || in_ready)
                    hold_bad++;
            end else begin
                mem_ready = 1'b1;
            end
        end else if (rmode == 2) begin
            mem_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] d);
        logic acc;
        acc = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int k = 0; k < 50 && !acc; k++) begin
            #1 acc = in_ready;
            @(posedge clk);
            @(negedge clk);
        end
        chk("send_accepted", 32'(acc), 32'd1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int k = 0; k < 40; k++) begin
            if (!busy && !frame_done) break;
            @(negedge clk);
        end
        chk(tag, 32'(busy), 32'd0);
    endtask

    task automatic chk_log(input string tag, input int base, input int n);
        chk({tag, "_count"}, 32'(la.size()), 32'(n));
        for (int i = 0; i < n && i < la.size(); i++) begin
            chk({tag, "_addr"}, la[i], 32'(i));
            chk({tag, "_data"}, 32'(ld[i]), 32'(base + i));
        end
    endtask

    task automatic clear_log();
        la.delete();
        ld.delete();
        lc.delete();
    endtask

    initial begin
        int d0;
        int cnt;
        logic acc;
        rst = 1'b1;
        start = 1'b0; in_valid = 1'b0; in_data = '0; mem_ready = 1'b1;
        start_b = 1'b0; in_valid_b = 1'b0; in_data_b = '0; mem_ready_b = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        @(negedge clk);

        // 1: full-rate frame, then a start coinciding with frame_done
        clear_log();
        pulse_start();
        chk("t1_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 6; i++) send(8'(10 + i));
        in_valid = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (frame_done) break;
            @(negedge clk);
        end
        chk("t1_done_seen", 32'(frame_done), 32'd1);
        pulse_start();
        #1;
        chk("t1_start_on_done_ignored", 32'(busy), 32'd0);
        chk_log("t1", 10, 6);
        if (lc.size() == 6) begin
            chk("t1_consecutive", 32'(lc[5] - lc[0]), 32'd5);
            chk("t1_done_after_last", 32'(done_cyc), 32'(lc[5] + 1));
        end
        chk("t1_done_once", 32'(done_a), 32'd1);

        // 2: three-cycle stall on the write to addr 2
        clear_log();
        rmode = 1;
        pulse_start();
        for (int i = 0; i < 6; i++) send(8'(20 + i));
        in_valid = 1'b0;
        wait_idle("t2_idle");
        chk_log("t2", 20, 6);
        chk("t2_stalls", 32'(stall_n), 32'd3);
        chk("t2_hold_stable", 32'(hold_bad), 32'd0);
        if (lc.size() == 6) chk("t2_stall_gap", 32'(lc[2] - lc[1]), 32'd4);
        chk("t2_done_once", 32'(done_a), 32'd2);

        // 3: random valid gaps and random memory readiness
        clear_log();
        rmode = 2;
        pulse_start();
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send(8'(30 + i));
        end
        in_valid = 1'b0;
        wait_idle("t3_idle");
        chk_log("t3", 30, 6);
        chk("t3_done_once", 32'(done_a), 32'd3);

        // 4: pixels offered in IDLE raise overflow; start clears it
        clear_log();
        rmode = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'd99;
        #1 chk("t4_idle_in_ready", 32'(in_ready), 32'd0);
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        chk("t4_overflow_set", 32'(overflow), 32'd1);
        repeat (2) @(negedge clk);
        chk("t4_overflow_sticky", 32'(overflow), 32'd1);
        chk("t4_nothing_written", 32'(la.size()), 32'd0);
        pulse_start();
        chk("t4_overflow_cleared", 32'(overflow), 32'd0);

        // 5: reset mid-frame with a write pending, then a clean frame
        send(8'd40);
        send(8'd41);
        send(8'd42);
        #2;
        rmode = 3;
        mem_ready = 1'b0;
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        rmode = 0;
        #1;
        chk("t5_mem_we", 32'(mem_we), 32'd0);
        chk("t5_mem_addr", mem_addr, 32'd0);
        chk("t5_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_in_ready", 32'(in_ready), 32'd0);
        chk("t5_overflow", 32'(overflow), 32'd0);
        chk_log("t5_pre", 40, 2);
        clear_log();
        @(negedge clk);
        pulse_start();
        for (int i = 0; i < 6; i++) send(8'(50 + i));
        in_valid = 1'b0;
        wait_idle("t5_idle");
        chk_log("t5", 50, 6);
        chk("t5_done_once", 32'(done_a), 32'd4);

        // 6: 4x317 frame streamed at full rate
        d0 = b_done;
        start_b = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_b = 1'b0;
        in_valid_b = 1'b1;
        cnt = 0;
        for (int k = 0; k < 3000 && cnt < 1268; k++) begin
            in_data_b = 8'(cnt);
            #1 acc = in_ready_b;
            @(posedge clk);
            @(negedge clk);
            if (acc) cnt++;
        end
        in_valid_b = 1'b0;
        chk("t6_accepted", 32'(cnt), 32'd1268);
        for (int k = 0; k < 20; k++) begin
            if (!busy_b && b_done != d0) break;
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
        chk("t6_write_count", 32'(b_wr_cnt), 32'd1268);
        chk("t6_last_addr", b_last, 32'd1267);
        chk("t6_sequence", 32'(b_seq_err), 32'd0);
        chk("t6_done_once", 32'(b_done - d0), 32'd1);
        chk("t6_idle", 32'(busy_b), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
